// File: rtl/slot_reel_bank.sv
// slot_reel_bank: three octal reels spun at 1x/2x/3x tick periods,
// frozen by stop buttons or by running falling; reports all_stop and win.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   running    spin enable from the sequencer (level)
//   stop_btn   per-reel stop buttons, bit i = reel i (level)
//   reel0..2   current reel symbols, 0-7
//   spinning   bit i high while reel i is in SPIN
//   all_stop   one-cycle pulse after the last reel halts
//   win        latched "all three symbols equal" after a game
module slot_reel_bank #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       running,
  input  logic [2:0] stop_btn,
  output logic [2:0] reel0,
  output logic [2:0] reel1,
  output logic [2:0] reel2,
  output logic [2:0] spinning,
  output logic       all_stop,
  output logic       win
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    HALT = 2'd2
  } reel_st_e;

  localparam logic [7:0] PMAX = 8'(PRESCALE - 1);

  reel_st_e   st_q [3];
  reel_st_e   st_d [3];
  logic [2:0] val_q [3];
  logic [1:0] div_q [3];
  logic [7:0] presc_q;
  logic       running_d;
  logic [2:0] btn_d;
  logic       done_pend;

  logic       run_rise;
  logic [2:0] btn_rise;
  logic       any_spin;
  logic       any_next;
  logic       tick;
  logic [2:0] keep;
  logic       all_eq;

  assign run_rise = running & ~running_d;
  assign btn_rise = stop_btn & ~btn_d;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) st_q[i] <= IDLE;
    end else begin
      for (int i = 0; i < 3; i++) st_q[i] <= st_d[i];
    end
  end

  // Next state; run_rise overrides any button edge
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        IDLE, HALT: if (run_rise) st_d[i] = SPIN;
        SPIN: begin
          if (!running || btn_rise[i]) st_d[i] = HALT;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  // Decoded outputs and per-reel qualifiers
  always_comb begin
    spinning = 3'b000;
    keep     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      spinning[i] = (st_q[i] == SPIN);
      keep[i]     = (st_q[i] == SPIN)
                  && (st_d[i] == SPIN);
    end
  end

  assign any_spin = |spinning;
  assign any_next = (st_d[0] == SPIN)
                  | (st_d[1] == SPIN)
                  | (st_d[2] == SPIN);
  assign tick     = any_spin && (presc_q == PMAX);
  assign all_eq   = (val_q[0] == val_q[1])
                  && (val_q[1] == val_q[2]);

  // A reel that halts this cycle takes no step, so stop beats advance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      running_d <= 1'b0;
      btn_d     <= 3'b000;
      presc_q   <= 8'd0;
      done_pend <= 1'b0;
      all_stop  <= 1'b0;
      win       <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        val_q[i] <= 3'd0;
        div_q[i] <= 2'd0;
      end
    end else begin
      running_d <= running;
      btn_d     <= stop_btn;
      done_pend <= any_spin & ~any_next;
      all_stop  <= done_pend;

      if (run_rise)      win <= 1'b0;
      else if (done_pend) win <= all_eq;

      if (run_rise) begin
        presc_q <= 8'd0;
      end else if (any_spin) begin
        if (presc_q == PMAX) presc_q <= 8'd0;
        else                 presc_q <= presc_q + 8'd1;
      end

      for (int i = 0; i < 3; i++) begin
        if (run_rise) begin
          div_q[i] <= 2'd0;
        end else if (tick && keep[i]) begin
          if (div_q[i] == 2'(i)) begin
            div_q[i] <= 2'd0;
            val_q[i] <= val_q[i] + 3'd1;
          end else begin
            div_q[i] <= div_q[i] + 2'd1;
          end
        end
      end
    end
  end

  assign reel0 = val_q[0];
  assign reel1 = val_q[1];
  assign reel2 = val_q[2];

endmodule

// File: tb/tb_slot_reel_bank.sv
// tb_slot_reel_bank: directed scenarios for slot_reel_bank
// with hand-computed reel values and pulse timing.
module tb_slot_reel_bank;

  logic       clock;
  logic       reset;
  logic       running;
  logic [2:0] stop_btn;
  logic [2:0] reel0;
  logic [2:0] reel1;
  logic [2:0] reel2;
  logic [2:0] spinning;
  logic       all_stop;
  logic       win;

  int vecs;
  int errs;
  int pulses;
  int p0;

  slot_reel_bank #(.PRESCALE(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .running  (running),
    .stop_btn (stop_btn),
    .reel0    (reel0),
    .reel1    (reel1),
    .reel2    (reel2),
    .spinning (spinning),
    .all_stop (all_stop),
    .win      (win)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (all_stop === 1'b1) pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    running = 1'b0;
    stop_btn = 3'b000;
    #2;
    vecs++;
    if ({reel2, reel1, reel0} !== 9'd0) begin
      errs++;
      $display("FAIL rst_reels got %h exp 000",
               {reel2, reel1, reel0});
    end
    vecs++;
    if ({spinning, all_stop, win} !== 5'd0) begin
      errs++;
      $display("FAIL rst_flags got %b exp 00000",
               {spinning, all_stop, win});
    end
    step(2);
    reset = 1'b1;
    step(2);
    stop_btn = 3'b111;
    step(1);
    stop_btn = 3'b000;
    step(3);
    vecs++;
    if ({reel2, reel1, reel0} !== 9'd0) begin
      errs++;
      $display("FAIL idle_btn_reels got %h exp 000",
               {reel2, reel1, reel0});
    end
    vecs++;
    if (spinning !== 3'b000 || win !== 1'b0) begin
      errs++;
      $display("FAIL idle_btn_flags got %b %b exp 000 0",
               spinning, win);
    end
    vecs++;
    if (pulses != 0) begin
      errs++;
      $display("FAIL idle_no_stop got %0d exp 0", pulses);
    end
  endtask

  task automatic test_spin32();
    running = 1'b1;
    step(1);
    vecs++;
    if (spinning !== 3'b111) begin
      errs++;
      $display("FAIL spin_start got %b exp 111", spinning);
    end
    step(32);
    vecs++;
    if (reel0 !== 3'd0 || reel1 !== 3'd4
        || reel2 !== 3'd2) begin
      errs++;
      $display("FAIL spin32 got %0d %0d %0d exp 0 4 2",
               reel0, reel1, reel2);
    end
    vecs++;
    if (spinning !== 3'b111) begin
      errs++;
      $display("FAIL spin32_sp got %b exp 111", spinning);
    end
  endtask

  task automatic test_stop_sequence();
    step(16);
    stop_btn = 3'b001;
    step(1);
    stop_btn = 3'b000;
    vecs++;
    if (spinning !== 3'b110 || reel0 !== 3'd4) begin
      errs++;
      $display("FAIL stop0 got %b %0d exp 110 4",
               spinning, reel0);
    end
    step(47);
    stop_btn = 3'b010;
    step(1);
    stop_btn = 3'b000;
    vecs++;
    if (spinning !== 3'b100 || reel1 !== 3'd4
        || reel0 !== 3'd4) begin
      errs++;
      $display("FAIL stop1 got %b %0d %0d exp 100 4 4",
               spinning, reel0, reel1);
    end
    step(47);
    p0 = pulses;
    stop_btn = 3'b100;
    step(1);
    stop_btn = 3'b000;
    vecs++;
    if (spinning !== 3'b000 || all_stop !== 1'b0) begin
      errs++;
      $display("FAIL stop2 got %b %b exp 000 0",
               spinning, all_stop);
    end
    step(1);
    vecs++;
    if (all_stop !== 1'b1 || win !== 1'b1) begin
      errs++;
      $display("FAIL win_pulse got %b %b exp 1 1",
               all_stop, win);
    end
    vecs++;
    if (reel0 !== 3'd4 || reel1 !== 3'd4
        || reel2 !== 3'd4) begin
      errs++;
      $display("FAIL frozen444 got %0d %0d %0d exp 4 4 4",
               reel0, reel1, reel2);
    end
    step(1);
    vecs++;
    if (all_stop !== 1'b0 || win !== 1'b1
        || pulses != p0 + 1) begin
      errs++;
      $display("FAIL win_hold got %b %b %0d exp 0 1 %0d",
               all_stop, win, pulses, p0 + 1);
    end
  endtask

  task automatic test_restart();
    p0 = pulses;
    running = 1'b0;
    step(1);
    running = 1'b1;
    step(1);
    vecs++;
    if (win !== 1'b0 || spinning !== 3'b111) begin
      errs++;
      $display("FAIL restart got %b %b exp 0 111",
               win, spinning);
    end
    vecs++;
    if (reel0 !== 3'd4 || reel1 !== 3'd4
        || reel2 !== 3'd4) begin
      errs++;
      $display("FAIL restart_val got %0d %0d %0d exp 4 4 4",
               reel0, reel1, reel2);
    end
    step(12);
    vecs++;
    if (reel0 !== 3'd7 || reel1 !== 3'd5
        || reel2 !== 3'd5) begin
      errs++;
      $display("FAIL resume got %0d %0d %0d exp 7 5 5",
               reel0, reel1, reel2);
    end
    vecs++;
    if (pulses != p0) begin
      errs++;
      $display("FAIL halt_drop got %0d exp %0d", pulses, p0);
    end
  endtask

  task automatic test_forced_halt();
    p0 = pulses;
    running = 1'b0;
    step(1);
    vecs++;
    if (spinning !== 3'b000 || all_stop !== 1'b0) begin
      errs++;
      $display("FAIL force got %b %b exp 000 0",
               spinning, all_stop);
    end
    step(1);
    vecs++;
    if (all_stop !== 1'b1 || win !== 1'b0) begin
      errs++;
      $display("FAIL force_pulse got %b %b exp 1 0",
               all_stop, win);
    end
    step(1);
    vecs++;
    if (all_stop !== 1'b0) begin
      errs++;
      $display("FAIL force_len got %b exp 0", all_stop);
    end
    step(8);
    vecs++;
    if (reel0 !== 3'd7 || reel1 !== 3'd5
        || reel2 !== 3'd5 || pulses != p0 + 1) begin
      errs++;
      $display("FAIL force_hold got %0d %0d %0d %0d exp 7 5 5 %0d",
               reel0, reel1, reel2, pulses, p0 + 1);
    end
  endtask

  task automatic test_stop_wins();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    running = 1'b1;
    step(1);
    step(31);
    stop_btn = 3'b010;
    step(1);
    stop_btn = 3'b000;
    vecs++;
    if (reel1 !== 3'd3 || reel0 !== 3'd0
        || reel2 !== 3'd2) begin
      errs++;
      $display("FAIL stopwin got %0d %0d %0d exp 0 3 2",
               reel0, reel1, reel2);
    end
    vecs++;
    if (spinning !== 3'b101) begin
      errs++;
      $display("FAIL stopwin_sp got %b exp 101", spinning);
    end
    step(4);
    vecs++;
    if (reel0 !== 3'd1 || reel1 !== 3'd3
        || reel2 !== 3'd3) begin
      errs++;
      $display("FAIL stopwin_run got %0d %0d %0d exp 1 3 3",
               reel0, reel1, reel2);
    end
  endtask

  task automatic test_reset_mid_spin();
    p0 = pulses;
    stop_btn = 3'b111;
    reset = 1'b0;
    #2;
    vecs++;
    if ({reel2, reel1, reel0} !== 9'd0
        || spinning !== 3'b000) begin
      errs++;
      $display("FAIL midrst got %h %b exp 000 000",
               {reel2, reel1, reel0}, spinning);
    end
    step(1);
    reset = 1'b1;
    step(1);
    vecs++;
    if (spinning !== 3'b111) begin
      errs++;
      $display("FAIL rise_btn got %b exp 111", spinning);
    end
    step(4);
    vecs++;
    if (spinning !== 3'b111 || reel0 !== 3'd1) begin
      errs++;
      $display("FAIL btn_held got %b %0d exp 111 1",
               spinning, reel0);
    end
    stop_btn = 3'b000;
    step(1);
    stop_btn = 3'b100;
    step(1);
    stop_btn = 3'b000;
    vecs++;
    if (spinning !== 3'b011) begin
      errs++;
      $display("FAIL fresh_btn got %b exp 011", spinning);
    end
    step(1);
    stop_btn = 3'b011;
    step(1);
    stop_btn = 3'b000;
    vecs++;
    if (spinning !== 3'b000 || reel0 !== 3'd1) begin
      errs++;
      $display("FAIL dual_btn got %b %0d exp 000 1",
               spinning, reel0);
    end
    step(1);
    vecs++;
    if (all_stop !== 1'b1 || win !== 1'b0
        || pulses != p0) begin
      errs++;
      $display("FAIL dual_pulse got %b %b %0d exp 1 0 %0d",
               all_stop, win, pulses, p0);
    end
    vecs++;
    if (reel0 !== 3'd1 || reel1 !== 3'd0
        || reel2 !== 3'd0) begin
      errs++;
      $display("FAIL dual_val got %0d %0d %0d exp 1 0 0",
               reel0, reel1, reel2);
    end
    step(1);
    vecs++;
    if (pulses != p0 + 1 || all_stop !== 1'b0) begin
      errs++;
      $display("FAIL dual_len got %0d %b exp %0d 0",
               pulses, all_stop, p0 + 1);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    pulses = 0;
    p0 = 0;
    reset = 1'b0;
    running = 1'b0;
    stop_btn = 3'b000;
    test_reset();
    test_spin32();
    test_stop_sequence();
    test_restart();
    test_forced_halt();
    test_stop_wins();
    test_reset_mid_spin();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/slot_reel_bank.md
Name: slot_reel_bank

Overview:
- Three-reel spinning/stopping datapath driven by the start/stop sequencer's `running` enable.
- Each reel is an octal (0-7) counter that advances at its own rate while spinning and freezes on its stop button.
- When the last reel halts, the block returns a one-cycle `all_stop` pulse, wired back to the sequencer's stop input, and a latched win flag for the display/payout logic.

Parameters:
- PRESCALE, 4: clock cycles per base tick; legal range 2..255; prescaler width 8 bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- running  input  1  spin enable from sequencer; synchronous level.
- stop_btn  input  3  per-reel stop buttons, bit i = reel i; already debounced and synchronous, level.
- reel0  output  3  reel 0 symbol, 0-7.
- reel1  output  3  reel 1 symbol.
- reel2  output  3  reel 2 symbol.
- spinning  output  3  bit i high while reel i is in SPIN.
- all_stop  output  1  one-cycle pulse when the last reel halts; drives sequencer stop.
- win  output  1  high when all three halted symbols are equal; latched.

Behaviour:

Reset (reset low, asynchronous):
- All reels 0, all reel states IDLE, spinning=0, all_stop=0, win=0.
- Prescaler, per-reel tick dividers, running_d and stop_btn_d all cleared to 0.

Edge detection:
- run_rise = running & ~running_d.
- btn_rise[i] = stop_btn[i] & ~stop_btn_d[i].
- Both delay registers update every cycle.

Per-reel state machine, states IDLE / SPIN / HALT:
- IDLE or HALT, run_rise -> SPIN. Reel value retained, not reloaded. Same cycle: win<=0, prescaler<=0, all dividers<=0.
- SPIN, btn_rise[i] -> HALT.
- SPIN, running low -> HALT (forced halt, e.g. sequencer reset). All spinning reels halt in the same cycle.
- btn_rise in IDLE or HALT is ignored.
- spinning[i] = (state_i == SPIN), decoded from registered state.

Tick generation:
- The prescaler runs only while any reel is in SPIN. It counts 0..PRESCALE-1 and wraps.
- tick = 1 when prescaler == PRESCALE-1 and any reel is in SPIN.
- The first SPIN cycle has prescaler=0.

Reel advance:
- Reel i holds a divider counting ticks modulo (i+1).
- On a tick with divider_i == i, reel i increments by 1 (7 wraps to 0) and divider_i returns to 0; on other ticks divider_i increments.
- Result: reel0 advances every tick, reel1 every 2nd tick, reel2 every 3rd tick.
- Reels in IDLE or HALT neither advance nor update their divider.

Simultaneous events:
- btn_rise and an advance in the same cycle: stop wins; the value does not increment.
- Multiple btn_rise bits in the same cycle: all those reels halt together.
- run_rise and btn_rise in the same cycle: the button is ignored; reels enter SPIN.

Completion:
- Registered flag done_pend is set in the cycle the last SPIN reel transitions to HALT, whether by button or forced halt.
- all_stop = done_pend for exactly one cycle, i.e. one cycle after the last reel freezes.
- In the same cycle win is loaded with (reel0==reel1==reel2) and holds until the next run_rise or reset.
- all_stop fires once per game; it never fires from IDLE.

Reset mid-spin:
- All state returns to reset values immediately.
- No all_stop is generated.

Test Plan:
- Reset, hold running=0, pulse stop_btn=3'b111 -> reels stay 0,0,0; spinning=0; all_stop never asserts; win=0.
- PRESCALE=4, raise running and hold 32 SPIN cycles -> reel0=0 (8 advances, wrapped), reel1=4, reel2=2; spinning=3'b111 from the cycle after run_rise.
- From the previous state, pulse stop_btn[0] then stop_btn[1] then stop_btn[2] on separate cycles between ticks:
  - the frozen values persist;
  - all_stop is high exactly one cycle, one cycle after stop_btn[2]'s halt;
  - win=1 iff the three frozen values are equal (check with the reel0/reel1/reel2 timing that lands 4,4,4).
- Assert stop_btn[1] on the same cycle reel1 would advance 3->4 -> reel1 freezes at 3; reel0 and reel2 keep spinning.
- Drop running while all three reels spin -> all spinning bits clear the next cycle; all_stop pulses one cycle later; values frozen. Raise running again -> win clears and all reels resume from their frozen values.
- Assert reset low mid-spin for 1 cycle -> reels 0,0,0, spinning=0, no all_stop pulse. Hold stop_btn high through reset release -> no halt until a fresh rising edge after a new run_rise.
